mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: WID_MEM, default 8, memory word width in bits.
REQ-002 Parameter: DEPTH_MEM, default 2048, number of memory words.
REQ-003 Port: clk  input  1  sole clock; all logic is on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: req_valid  input  2  per-requester request valid (bit i = requester i).
REQ-006 Port: req_we  input  2  per-requester write (1) or read (0).
REQ-007 Port: req_addr  input  2x32  per-requester word address.
REQ-008 Port: req_wdata  input  2xWID_MEM  per-requester write data.
REQ-009 Port: req_ready  output  2  per-requester accept.
REQ-010 Port: rsp_valid  output  2  per-requester response strobe, one cycle wide.
REQ-011 Port: rsp_err  output  1  response was out-of-range; qualified by rsp_valid.
REQ-012 Port: rsp_rdata  output  WID_MEM  read data; qualified by rsp_valid.
REQ-013 Port: clr_start  input  1  pulse that starts a full-memory clear.
REQ-014 Port: clr_value  input  WID_MEM  fill word for the clear; sampled with clr_start.
REQ-015 Port: clr_busy  output  1  high while the clear sequence runs.
REQ-016 Port: clr_done  output  1  one-cycle pulse after the last clear write.
REQ-017 Port: mem_raddr  output  32  memory read address, registered.
REQ-018 Port: mem_waddr  output  32  memory write address, registered.
REQ-019 Port: mem_we  output  1  memory write enable, registered.
REQ-020 Port: mem_din  output  WID_MEM  memory write data, registered.
REQ-021 Port: mem_dout  input  WID_MEM  memory read data, one cycle after mem_raddr.

Function
REQ-022 The FSM has two states: IDLE and CLEAR.
REQ-023 In IDLE, at most one request is accepted per cycle.
- req_ready[i] = req_valid[i] && grant[i] (combinational).
- An accept is req_valid[i] && req_ready[i].
REQ-024 Arbitration is round-robin.
- If one requester is valid, it is granted.
- If both are valid, the requester not granted most recently is granted.
- The last-grant pointer updates only on an accept.
REQ-025 Address range check:
- An accept with req_addr >= DEPTH_MEM generates no memory write.
- It returns rsp_err=1 and rsp_rdata=0 at the normal response latency.
REQ-026 Accept at edge T:
- mem_raddr/mem_waddr = req_addr from edge T.
- mem_we = req_we from edge T, and only if the address is in range.
- mem_din = req_wdata from edge T.
REQ-027 Response at cycle T+2: rsp_valid[i]=1 for the accepted requester, for reads and writes.
- Reads: rsp_rdata = mem_dout.
- Writes: rsp_rdata = 0.
- rsp_err = 0 for in-range accesses.
REQ-028 Throughput is one access per cycle; back-to-back accepts produce back-to-back responses in accept order.
REQ-029 When a write and a read to the same address are accepted on consecutive cycles, the read returns the newly written data.
REQ-030 A clr_start seen in IDLE has priority over any request in the same cycle.
- req_ready = 0 for that cycle.
- The FSM enters CLEAR and clr_value is latched.
REQ-031 CLEAR behaviour:
- Issues one write per cycle, mem_waddr = 0 .. DEPTH_MEM-1, mem_din = latched value.
- req_ready = 0 and clr_busy = 1 throughout.
REQ-032 After the write to DEPTH_MEM-1 is issued:
- clr_done pulses for one cycle.
- The FSM returns to IDLE.
- Requests are accepted again from the next cycle.
REQ-033 clr_start during CLEAR is ignored; the sequence does not restart.
REQ-034 Responses for accesses accepted before CLEAR still complete at T+2; clear writes never corrupt an in-flight read.
REQ-035 mem_we = 0 in any cycle with no accepted write and no clear write.

Reset
REQ-036 On reset, all outputs are 0, the FSM is in IDLE, and the last-grant pointer is 1 (requester 0 wins the first tie).
REQ-037 Reset during CLEAR aborts the clear with no clr_done; reset discards in-flight responses.

Structure
REQ-038 Package mem_arb_pkg holds:
- the state enum (IDLE, CLEAR);
- typedef req_id_t (1 bit);
- the constant NUM_REQ = 2.
REQ-039 Sub-module rr_arb2 holds the round-robin grant and pointer; the FSM, clear counter and response pipeline stay in mem_port_arbiter.

Verification
REQ-040 Requester 0 writes 0xA5 to address 5, then reads address 5: rsp_valid[0] is high at T+2 of the read, rsp_rdata=0xA5, rsp_err=0.
REQ-041 Both requesters are valid for 4 cycles: grants alternate 0,1,0,1 and responses arrive in that order.
REQ-042 Requester 1 reads address 2048: no mem_we, rsp_err=1, rsp_rdata=0.
REQ-043 clr_start with clr_value=0x3C while both requesters are valid:
- No accepts for 2048 cycles.
- clr_done pulses once, then a read of address 2047 returns 0x3C.
REQ-044 Reset asserted at clear address 100: clr_busy=0 and no clr_done; address 100 keeps its old contents, and addresses 0..99 read 0x3C.
REQ-045 A write is accepted at cycle T and a read of the same address at T+1: the read returns the written data.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
package mem_arb_pkg;

    // Number of requesters sharing the memory port
    localparam int NUM_REQ = 2;

    // Top-level controller states: serving requests, or sweeping the memory
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // Requester index
    typedef logic [0:0] req_id_t;

    // One slot of the response pipeline that tracks an accepted access
    typedef struct packed {
        logic    valid;
        req_id_t id;
        logic    we;
        logic    err;
    } rsp_stage_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; the pointer remembers the last requester served.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic               clk,
    input  logic               i_reset,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_update,
    input  req_id_t            i_update_id,
    output logic [NUM_REQ-1:0] o_grant
);

    req_id_t r_last;

    // Track the most recently served requester; starts at 1 so requester 0 wins the first tie
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_last <= 1'b1;
        end else if (i_update) begin
            r_last <= i_update_id;
        end
    end

    // Lone requester wins; on a tie the one not served last wins
    always_comb begin
        o_grant = '0;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = (r_last == 1'b1) ? 2'b01 : 2'b10;
            default: o_grant = '0;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one registered memory port between two requesters and a full-memory
// clear engine. Responses come back two cycles after accept, in accept order.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WID_MEM   = 8,
    parameter int DEPTH_MEM = 2048
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_we,
    input  logic [NUM_REQ-1:0][31:0]         req_addr,
    input  logic [NUM_REQ-1:0][WID_MEM-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic                             rsp_err,
    output logic [WID_MEM-1:0]               rsp_rdata,
    input  logic                             clr_start,
    input  logic [WID_MEM-1:0]               clr_value,
    output logic                             clr_busy,
    output logic                             clr_done,
    output logic [31:0]                      mem_raddr,
    output logic [31:0]                      mem_waddr,
    output logic                             mem_we,
    output logic [WID_MEM-1:0]               mem_din,
    input  logic [WID_MEM-1:0]               mem_dout
);

    localparam int                CNT_W    = (DEPTH_MEM > 1) ? $clog2(DEPTH_MEM) : 1;
    localparam logic [31:0]       DEPTH_U  = 32'(DEPTH_MEM);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEPTH_MEM - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic                w_accept_en;
    logic                w_clearing;
    logic                w_clr_last;

    logic [NUM_REQ-1:0]  w_grant;
    logic                w_accept;
    req_id_t             w_sel_id;
    logic [31:0]         w_sel_addr;
    logic                w_sel_we;
    logic [WID_MEM-1:0]  w_sel_wdata;
    logic                w_sel_in_range;

    logic [CNT_W-1:0]    r_clr_cnt;
    logic [WID_MEM-1:0]  r_clr_value;
    logic                r_clr_done;

    logic [31:0]         r_mem_raddr;
    logic [31:0]         r_mem_waddr;
    logic                r_mem_we;
    logic [WID_MEM-1:0]  r_mem_din;

    rsp_stage_t          r_stage1;
    rsp_stage_t          r_stage2;
    logic [NUM_REQ-1:0]  w_rsp_hit;
    logic [NUM_REQ-1:0]  r_rsp_valid;
    logic                r_rsp_err;
    logic [WID_MEM-1:0]  r_rsp_rdata;

    // ---------------------------------------------------------------- arbitration
    rr_arb2 u_rr_arb2 (
        .clk         (clk),
        .i_reset     (reset),
        .i_req       (req_valid),
        .i_update    (w_accept),
        .i_update_id (w_sel_id),
        .o_grant     (w_grant)
    );

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
        assign req_ready[gi] = req_valid[gi] & w_grant[gi] & w_accept_en;
    end

    // At most one bit of req_ready is set, so bit 1 alone identifies the winner
    assign w_accept       = |req_ready;
    assign w_sel_id       = req_ready[1];
    assign w_sel_addr     = req_addr[w_sel_id];
    assign w_sel_we       = req_we[w_sel_id];
    assign w_sel_wdata    = req_wdata[w_sel_id];
    assign w_sel_in_range = (w_sel_addr < DEPTH_U);

    // ---------------------------------------------------------------- FSM
    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: a clear start wins over requests; leave CLEAR once the last word is issued
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (clr_start)  w_state_next = CLEAR;
            CLEAR:   if (w_clr_last) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State-derived controls: requests only in IDLE without a simultaneous clear start
    always_comb begin
        w_accept_en = 1'b0;
        w_clearing  = 1'b0;
        clr_busy    = 1'b0;
        case (r_state)
            IDLE: begin
                w_accept_en = !clr_start && !reset;
            end
            CLEAR: begin
                w_clearing = 1'b1;
                clr_busy   = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_clr_last = w_clearing && (r_clr_cnt == CNT_LAST);

    // ---------------------------------------------------------------- clear engine
    // Latch the fill word on start and step the sweep address each CLEAR cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clr_cnt   <= '0;
            r_clr_value <= '0;
        end else if (r_state == IDLE && clr_start) begin
            r_clr_cnt   <= '0;
            r_clr_value <= clr_value;
        end else if (w_clearing) begin
            r_clr_cnt   <= r_clr_cnt + CNT_W'(1);
        end
    end

    // Completion strobe lands in the first IDLE cycle after the final clear write
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clr_done <= 1'b0;
        end else begin
            r_clr_done <= w_clr_last;
        end
    end

    // ---------------------------------------------------------------- memory port
    // Register the port from either a clear step or the accepted request; write only in range
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_raddr <= '0;
            r_mem_waddr <= '0;
            r_mem_we    <= 1'b0;
            r_mem_din   <= '0;
        end else begin
            r_mem_we <= 1'b0;
            if (w_clearing) begin
                r_mem_waddr <= 32'(r_clr_cnt);
                r_mem_din   <= r_clr_value;
                r_mem_we    <= 1'b1;
            end else if (w_accept) begin
                r_mem_raddr <= w_sel_addr;
                r_mem_waddr <= w_sel_addr;
                r_mem_din   <= w_sel_wdata;
                r_mem_we    <= w_sel_we & w_sel_in_range;
            end
        end
    end

    // ---------------------------------------------------------------- responses
    // Two-stage tracker aligns each accept with the memory read latency
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stage1 <= '0;
            r_stage2 <= '0;
        end else begin
            r_stage1.valid <= w_accept;
            r_stage1.id    <= w_sel_id;
            r_stage1.we    <= w_sel_we;
            r_stage1.err   <= !w_sel_in_range;
            r_stage2       <= r_stage1;
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp_hit
        assign w_rsp_hit[gi] = r_stage2.valid && (r_stage2.id == req_id_t'(gi));
    end

    // Register the response; read data only for in-range reads, zero otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_valid <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= w_rsp_hit;
            r_rsp_err   <= r_stage2.valid && r_stage2.err;
            r_rsp_rdata <= (r_stage2.valid && !r_stage2.we && !r_stage2.err) ? mem_dout : '0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;
    assign clr_done  = r_clr_done;
    assign mem_raddr = r_mem_raddr;
    assign mem_waddr = r_mem_waddr;
    assign mem_we    = r_mem_we;
    assign mem_din   = r_mem_din;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural 2048x8 memory attached.
module tb_mem_port_arbiter;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       req_valid;
    logic [1:0]       req_we;
    logic [1:0][31:0] req_addr;
    logic [1:0][7:0]  req_wdata;
    logic [1:0]       req_ready;
    logic [1:0]       rsp_valid;
    logic             rsp_err;
    logic [7:0]       rsp_rdata;
    logic             clr_start;
    logic [7:0]       clr_value;
    logic             clr_busy;
    logic             clr_done;
    logic [31:0]      mem_raddr;
    logic [31:0]      mem_waddr;
    logic             mem_we;
    logic [7:0]       mem_din;
    logic [7:0]       mem_dout;

    always #5 clk = ~clk;

    mem_port_arbiter #(.WID_MEM(8), .DEPTH_MEM(2048)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .clr_start (clr_start),
        .clr_value (clr_value),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .mem_raddr (mem_raddr),
        .mem_waddr (mem_waddr),
        .mem_we    (mem_we),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

    // Behavioural memory: one-cycle registered read, preloaded with mem[a] = a[7:0]
    logic [7:0] mem_model [0:2047];
    logic       mem_init;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int a = 0; a < 2048; a++) mem_model[a] <= 8'(a);
            mem_dout <= '0;
        end else begin
            if (mem_we) mem_model[mem_waddr[10:0]] <= mem_din;
            mem_dout <= mem_model[mem_raddr[10:0]];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    typedef struct {
        int         id;
        logic       err;
        logic [7:0] rdata;
        int         cyc;
    } exp_t;

    exp_t exp_q [$];
    exp_t mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every presented response is popped and compared against the scoreboard
    always @(negedge clk) begin
        if (!reset && rsp_valid != 2'b00) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: rsp_valid=%b with nothing outstanding (cycle %0d)", rsp_valid, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                $display("rsp req=%0d err=%0d rdata=%02h cycle=%0d", mon_e.id, rsp_err, rsp_rdata, cyc);
                chk("rsp_valid", {30'd0, rsp_valid}, (mon_e.id == 0) ? 32'd1 : 32'd2);
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, mon_e.err});
                chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, mon_e.rdata});
                chk("rsp_cycle", cyc, mon_e.cyc);
            end
        end
    end

    always @(negedge clk) if (clr_done) done_cnt++;

    // Present one request, wait for its accept, queue the expected response, check the memory port
    task automatic issue(input int id, input logic we, input logic [31:0] addr, input logic [7:0] wdata,
                         input logic [7:0] exp_rdata, input logic exp_err);
        int   n;
        exp_t e;
        @(negedge clk);
        req_valid       = '0;
        req_valid[id]   = 1'b1;
        req_we[id]      = we;
        req_addr[id]    = addr;
        req_wdata[id]   = wdata;
        #1;
        n = 0;
        while (!req_ready[id] && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!req_ready[id]) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: req %0d addr %0h never accepted, required accept", id, addr);
            req_valid = '0;
            return;
        end
        e.id    = id;
        e.err   = exp_err;
        e.rdata = exp_rdata;
        e.cyc   = cyc + 3;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        req_valid = '0;
        chk("mem_we", {31'd0, mem_we}, {31'd0, we && !exp_err});
        chk("mem_waddr", mem_waddr, addr);
        chk("mem_raddr", mem_raddr, addr);
        if (we) chk("mem_din", {24'd0, mem_din}, {24'd0, wdata});
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic drain();
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(negedge clk);
    endtask

    logic [1:0] rr_grant [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [7:0] rr_data  [4] = '{8'h0A, 8'h15, 8'h0C, 8'h17};

    initial begin
        int   busy_cnt;
        int   acc_cnt;
        int   bad_din;
        int   done_before;
        logic seen;
        logic found;
        exp_t e;

        reset     = 1'b1;
        mem_init  = 1'b1;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        clr_start = 1'b0;
        clr_value = '0;
        @(posedge clk);
        #1 mem_init = 1'b0;
        idle(3);

        // Reset state
        @(negedge clk);
        chk("rst_rsp_valid", {30'd0, rsp_valid}, 0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 0);
        chk("rst_rsp_rdata", {24'd0, rsp_rdata}, 0);
        chk("rst_req_ready", {30'd0, req_ready}, 0);
        chk("rst_clr_busy", {31'd0, clr_busy}, 0);
        chk("rst_clr_done", {31'd0, clr_done}, 0);
        chk("rst_mem_we", {31'd0, mem_we}, 0);
        chk("rst_mem_raddr", mem_raddr, 0);
        chk("rst_mem_waddr", mem_waddr, 0);
        chk("rst_mem_din", {24'd0, mem_din}, 0);
        reset = 1'b0;

        // Both requesters valid for four cycles: grants alternate starting with requester 0
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            req_valid   = 2'b11;
            req_we      = 2'b00;
            req_addr[0] = 32'(10 + k);
            req_addr[1] = 32'(20 + k);
            #1;
            chk("rr_grant", {30'd0, req_ready}, {30'd0, rr_grant[k]});
            e.id    = (rr_grant[k] == 2'b10) ? 1 : 0;
            e.err   = 1'b0;
            e.rdata = rr_data[k];
            e.cyc   = cyc + 3;
            exp_q.push_back(e);
            @(posedge clk);
        end
        #1 req_valid = '0;

        // Write then immediate read of the same address, and a spaced write/read
        issue(0, 1'b1, 32'd5,   8'hA5, 8'h00, 1'b0);
        issue(0, 1'b0, 32'd5,   8'h00, 8'hA5, 1'b0);
        issue(1, 1'b1, 32'd7,   8'h5E, 8'h00, 1'b0);
        issue(0, 1'b0, 32'd7,   8'h00, 8'h5E, 1'b0);
        issue(1, 1'b1, 32'd300, 8'h77, 8'h00, 1'b0);
        idle(3);
        issue(1, 1'b0, 32'd300, 8'h00, 8'h77, 1'b0);

        // Out-of-range accesses: error response, zero data, no memory write
        issue(1, 1'b0, 32'd2048,       8'h00, 8'h00, 1'b1);
        issue(0, 1'b1, 32'h0001_0000,  8'hFF, 8'h00, 1'b1);
        issue(0, 1'b0, 32'd0,          8'h00, 8'h00, 1'b0);

        // Read in flight when a clear starts, with both requesters pending
        issue(1, 1'b0, 32'd40, 8'h00, 8'h28, 1'b0);
        @(negedge clk);
        req_valid   = 2'b11;
        req_we      = 2'b00;
        req_addr[0] = 32'd16;
        req_addr[1] = 32'd17;
        clr_start   = 1'b1;
        clr_value   = 8'h3C;
        #1;
        chk("clr_start_blocks_ready", {30'd0, req_ready}, 0);
        @(posedge clk);
        #1;
        clr_start   = 1'b0;
        clr_value   = 8'h99;
        done_before = done_cnt;
        busy_cnt    = 0;
        acc_cnt     = 0;
        bad_din     = 0;
        seen        = 1'b0;
        for (int n = 0; n < 3000 && !seen; n++) begin
            @(negedge clk);
            if (req_ready != 2'b00) acc_cnt++;
            if (clr_busy) busy_cnt++;
            if (mem_we && mem_din !== 8'h3C) bad_din++;
            if (clr_done) seen = 1'b1;
            if (n == 8) req_valid = '0;
            if (n == 500) clr_start = 1'b1;
            if (n == 501) clr_start = 1'b0;
        end
        chk("clr_done_seen", {31'd0, seen}, 1);
        chk("clr_busy_at_done", {31'd0, clr_busy}, 0);
        // First cycle after the sweep accepts requests again
        req_valid   = 2'b01;
        req_we      = 2'b00;
        req_addr[0] = 32'd2047;
        #1;
        chk("ready_after_clear", {30'd0, req_ready}, 1);
        e.id    = 0;
        e.err   = 1'b0;
        e.rdata = 8'h3C;
        e.cyc   = cyc + 3;
        exp_q.push_back(e);
        @(posedge clk);
        #1 req_valid = '0;
        chk("clr_busy_cycles", busy_cnt, 2048);
        chk("clr_accepts", acc_cnt, 0);
        chk("clr_fill_word", bad_din, 0);
        idle(3);
        chk("clr_done_pulses", done_cnt - done_before, 1);
        issue(1, 1'b0, 32'd0,    8'h00, 8'h3C, 1'b0);
        issue(0, 1'b0, 32'd1000, 8'h00, 8'h3C, 1'b0);

        // Reset while the clear is at address 100
        issue(0, 1'b1, 32'd0,   8'h11, 8'h00, 1'b0);
        issue(1, 1'b1, 32'd50,  8'h22, 8'h00, 1'b0);
        issue(0, 1'b1, 32'd99,  8'h33, 8'h00, 1'b0);
        issue(1, 1'b1, 32'd100, 8'hE1, 8'h00, 1'b0);
        drain();
        done_before = done_cnt;
        @(negedge clk);
        clr_start = 1'b1;
        clr_value = 8'h3C;
        @(posedge clk);
        #1 clr_start = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 400 && !found; n++) begin
            @(negedge clk);
            if (mem_we && mem_waddr == 32'd99) found = 1'b1;
        end
        chk("clr_reached_99", {31'd0, found}, 1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_clr_busy", {31'd0, clr_busy}, 0);
        chk("abort_mem_we", {31'd0, mem_we}, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle(5);
        chk("abort_no_done", done_cnt - done_before, 0);
        issue(0, 1'b0, 32'd0,   8'h00, 8'h3C, 1'b0);
        issue(1, 1'b0, 32'd50,  8'h00, 8'h3C, 1'b0);
        issue(0, 1'b0, 32'd99,  8'h00, 8'h3C, 1'b0);
        issue(1, 1'b0, 32'd100, 8'h00, 8'hE1, 1'b0);
        issue(0, 1'b0, 32'd101, 8'h00, 8'h3C, 1'b0);

        drain();
        idle(2);
        chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
